// File: rtl/cla_pkg.sv
// Shared definitions for the CLA frame accumulator.
//   WIDTH_DEFAULT : operand/sum width (only 8 is supported)
//   OPCNT_W       : width of the per-frame operand counter
//   SETCNT_W      : width of the adder settle counter
//   acc_state_t   : accumulator control states
package cla_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;
    localparam int unsigned OPCNT_W       = 8;
    localparam int unsigned SETCNT_W      = 4;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } acc_state_t;

endpackage

// File: rtl/cla8_adder.sv
// 8-bit combinational carry-lookahead adder.
// Ports:
//   a, b : 8-bit addends
//   cin  : carry in
//   sum  : 8-bit sum
//   cout : carry out of bit 7
module cla8_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       carry;
    logic       prop;

    // Each carry is the flat sum-of-products of generate/propagate terms, so no carry
    // depends on a lower carry signal.
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        c[0]  = cin;
        carry = 1'b0;
        prop  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            carry = g[i];
            prop  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry = carry | (prop & g[j]);
                prop  = prop & p[j];
            end
            carry    = carry | (prop & cin);
            c[i + 1] = carry;
        end
        sum  = p ^ c[7:0];
        cout = c[8];
    end

endmodule

// File: rtl/cla8_frame_accumulator.sv
// Frame accumulator around the 8-bit CLA. Accepts operands on a valid/ready handshake, adds
// each one to the running total after giving the adder SETTLE edges to settle, and after
// FRAME_LEN operands presents the frame total and a sticky overflow flag.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake, in_data is the operand
//   out_valid/out_ready  : result handshake
//   out_sum, out_ovf     : frame total and sticky carry-out (valid while out_valid=1)
// Optional feature: define CLA_ACC_SATURATE_EN to saturate the total at 8'hFF on carry-out.
module cla8_frame_accumulator #(
    parameter int unsigned WIDTH     = cla_pkg::WIDTH_DEFAULT,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned SETTLE    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf
);

    import cla_pkg::*;

    localparam logic [SETCNT_W-1:0] SETTLE_LOAD = SETCNT_W'(SETTLE - 1);
    localparam logic [OPCNT_W-1:0]  FRAME_CNT   = OPCNT_W'(FRAME_LEN);

    acc_state_t          state_q, state_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic                ovf_q, ovf_d;
    logic [OPCNT_W-1:0]  opcnt_q, opcnt_d;
    logic [SETCNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0]    add_sum;
    logic                add_cout;
    logic [WIDTH-1:0]    acc_next;
    logic [OPCNT_W-1:0]  opcnt_inc;

    cla8_adder u_adder (
        .a    (acc_q),
        .b    (opnd_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign opcnt_inc = opcnt_q + OPCNT_W'(1);

    always_comb begin
`ifdef CLA_ACC_SATURATE_EN
        // Once pinned at full scale with overflow seen, the total stays pinned.
        if (add_cout || (ovf_q && (acc_q == '1))) begin
            acc_next = '1;
        end else begin
            acc_next = add_sum;
        end
`else
        acc_next = add_sum;
`endif
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        ovf_d   = ovf_q;
        opcnt_d = opcnt_q;
        cnt_d   = cnt_q;
        case (state_q)
            cla_pkg::ACCEPT: begin
                if (in_valid) begin
                    opnd_d  = in_data;
                    cnt_d   = SETTLE_LOAD;
                    state_d = cla_pkg::SETTLE;
                end
            end
            cla_pkg::SETTLE: begin
                if (cnt_q == '0) begin
                    acc_d   = acc_next;
                    ovf_d   = ovf_q | add_cout;
                    opcnt_d = opcnt_inc;
                    state_d = (opcnt_inc == FRAME_CNT) ? cla_pkg::DONE : cla_pkg::ACCEPT;
                end else begin
                    cnt_d = cnt_q - SETCNT_W'(1);
                end
            end
            cla_pkg::DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    opcnt_d = '0;
                    state_d = cla_pkg::ACCEPT;
                end
            end
            default: begin
                state_d = cla_pkg::ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= cla_pkg::ACCEPT;
            acc_q   <= '0;
            opnd_q  <= '0;
            ovf_q   <= 1'b0;
            opcnt_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            ovf_q   <= ovf_d;
            opcnt_q <= opcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == cla_pkg::ACCEPT);
    assign out_valid = (state_q == cla_pkg::DONE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla8_frame_accumulator.sv
// Self-checking bench for cla8_frame_accumulator (default parameters). Expected frame
// results come from the unwrapped integer total of the frame's operands.
module tb_cla8_frame_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_ovf;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    cla8_frame_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s timed out waiting for handshake", tag);
    endtask

    // {ovf, sum} from the true (unwrapped) frame total.
    function automatic logic [8:0] expect_of(input int total);
        logic       ovf;
        logic [7:0] s;
        ovf = (total >= 256);
`ifdef CLA_ACC_SATURATE_EN
        s = ovf ? 8'hFF : 8'(total);
`else
        s = 8'(total % 256);
`endif
        return {ovf, s};
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send_op(input logic [7:0] d);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            timeout_fail("send_op");
        end else begin
            in_valid = 1'b1;
            in_data  = d;
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    task automatic wait_result(input string tag, input int total, input int hold);
        int         n;
        logic [8:0] e;
        n = 0;
        e = expect_of(total);
        while (!out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            timeout_fail(tag);
            return;
        end
        check({tag, "_sum"}, 32'(out_sum), 32'(e[7:0]));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(e[8]));
        check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        if (hold > 0) begin
            out_ready = 1'b0;
            for (int k = 0; k < hold; k++) begin
                in_valid = 1'b1;
                in_data  = 8'h33;
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_sum"}, 32'(out_sum), 32'(e[7:0]));
                check({tag, "_hold_ovf"}, 32'(out_ovf), 32'(e[8]));
                check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] ops[4], input int max_gap,
                             input int hold);
        int total;
        total = 0;
        for (int i = 0; i < 4; i++) begin
            send_op(ops[i]);
            total += int'(ops[i]);
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
        wait_result(tag, total, hold);
    endtask

    initial begin
        logic [7:0] f[4];
        int         e0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset held 3 cycles with an in_valid pulse inside it.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        check("rst_no_accept", 32'(in_ready), 32'd1);

        // Back-to-back 1,2,3,4 with out_ready already high; measure out_valid latency.
        out_ready = 1'b1;
        e0 = edge_cnt + 1;
        send_op(8'd1);
        send_op(8'd2);
        send_op(8'd3);
        send_op(8'd4);
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        check("b2b_latency", 32'(edge_cnt - e0), 32'd11);
        wait_result("b2b", 10, 0);

        // Overflow frame.
        f = '{8'h80, 8'h90, 8'h01, 8'h02};
        run_frame("ovf", f, 0, 0);

        // Backpressure with ignored in_valid, then 1,1,1,1.
        f = '{8'h01, 8'h01, 8'h01, 8'h01};
        run_frame("bp_pre", f, 0, 5);
        run_frame("bp_post", f, 0, 0);

        // Mid-frame abort after two accepted operands.
        send_op(8'hF0);
        send_op(8'h20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_sum", 32'(out_sum), 32'd0);
        check("abort_out_ovf", 32'(out_ovf), 32'd0);
        f = '{8'd5, 8'd5, 8'd5, 8'd5};
        run_frame("abort_next", f, 0, 0);

        // Same operands with and without idle gaps.
        f = '{8'd10, 8'd20, 8'd30, 8'd40};
        run_frame("gap_free", f, 0, 0);
        run_frame("gaps", f, 3, 0);

        // Random frames with random gaps and backpressure.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 4; i++) f[i] = 8'($urandom_range(0, 255));
            run_frame($sformatf("rand%0d", r), f, 3, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
